// File: rtl/al_accel_act_func_unit.sv
// Registered activation-function unit: ReLU, ReLU6, PWL sigmoid and PWL tanh
// on one signed fixed-point sample per enabled clock.
module al_accel_act_func_unit #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned FRAC_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  input  logic [DATA_W-1:0] act_func_di,
  input  logic [2:0]        act_func_typ,
  output logic [DATA_W-1:0] act_func_do
);

  // Internal width is wide enough for 2*|x| with four extra fractional bits,
  // so the most-negative input never wraps. FRAC_W must be at least 1.
  localparam int unsigned IW = DATA_W + 8;
  localparam int unsigned IF = FRAC_W + 4;

  localparam logic [2:0] TYP_RELU    = 3'd0;
  localparam logic [2:0] TYP_RELU6   = 3'd1;
  localparam logic [2:0] TYP_SIGMOID = 3'd2;
  localparam logic [2:0] TYP_TANH    = 3'd3;

  // Constants at the internal precision (IF fractional bits)
  localparam logic signed [IW-1:0] ONE_I     = IW'(1 << IF);
  localparam logic signed [IW-1:0] SIG_A5    = IW'(5 << IF);
  localparam logic signed [IW-1:0] SIG_A2375 = IW'(19 << (IF - 3));
  localparam logic signed [IW-1:0] SIG_C1    = IW'(27 << (IF - 5));
  localparam logic signed [IW-1:0] SIG_C2    = IW'(5 << (IF - 3));
  localparam logic signed [IW-1:0] SIG_C3    = IW'(1 << (IF - 1));
  localparam logic signed [IW-1:0] RND_I     = IW'(8);

  // Constants at the output precision (FRAC_W fractional bits)
  localparam logic signed [IW-1:0] ONE_O   = IW'(1 << FRAC_W);
  localparam logic signed [IW-1:0] MAX_O   = IW'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [IW-1:0] MIN_O   = IW'(-(1 << (DATA_W - 1)));
  localparam logic signed [IW-1:0] SIX_RAW = IW'(6 << FRAC_W);
  localparam logic signed [IW-1:0] SIX_O   = (SIX_RAW > MAX_O) ? MAX_O : SIX_RAW;

  // Piecewise-linear sigmoid on an IF-fraction argument, shift-only slopes
  function automatic logic signed [IW-1:0] sig_pwl(input logic signed [IW-1:0] v);
    logic signed [IW-1:0] a;
    logic signed [IW-1:0] y;
    a = (v < 0) ? -v : v;
    if (a >= SIG_A5)         y = ONE_I;
    else if (a >= SIG_A2375) y = (a >>> 5) + SIG_C1;
    else if (a >= ONE_I)     y = (a >>> 3) + SIG_C2;
    else                     y = (a >>> 2) + SIG_C3;
    return (v < 0) ? (ONE_I - y) : y;
  endfunction

  // Round half-up back to FRAC_W fractional bits, clamp to [-1,1] and to range
  function automatic logic signed [IW-1:0] round_clamp(input logic signed [IW-1:0] v);
    logic signed [IW-1:0] r;
    r = (v + RND_I) >>> 4;
    if (r > ONE_O)  r = ONE_O;
    if (r < -ONE_O) r = -ONE_O;
    if (r > MAX_O)  r = MAX_O;
    if (r < MIN_O)  r = MIN_O;
    return r;
  endfunction

  logic signed [IW-1:0] x_w;
  logic signed [IW-1:0] res_c;

  assign x_w = IW'($signed(act_func_di));

  // Combinational function select
  always_comb begin
    res_c = '0;
    case (act_func_typ)
      TYP_RELU: begin
        res_c = (x_w < 0) ? '0 : x_w;
      end
      TYP_RELU6: begin
        if (x_w < 0)          res_c = '0;
        else if (x_w > SIX_O) res_c = SIX_O;
        else                  res_c = x_w;
      end
      TYP_SIGMOID: begin
        res_c = round_clamp(sig_pwl(x_w <<< 4));
      end
      TYP_TANH: begin
        res_c = round_clamp((sig_pwl(x_w <<< 5) <<< 1) - ONE_I);
      end
      default: begin
        res_c = '0;
      end
    endcase
  end

  // Output register: reset wins over enable, holds when enb is low
  always_ff @(posedge clk) begin
    if (reset) begin
      act_func_do <= '0;
    end else if (enb) begin
      act_func_do <= DATA_W'(res_c);
    end
  end

endmodule

// File: tb/tb_al_accel_act_func_unit.sv
// Self-checking bench for al_accel_act_func_unit: directed cases plus
// randomized stimulus against a fixed-point arithmetic reference model.
module tb_al_accel_act_func_unit;

  logic       clk;
  logic       reset;
  logic       enb;
  logic [7:0] act_func_di;
  logic [2:0] act_func_typ;
  logic [7:0] act_func_do;

  int n_cmp;
  int n_err;
  logic [7:0] model_q;

  al_accel_act_func_unit #(.DATA_W(8), .FRAC_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .enb          (enb),
    .act_func_di  (act_func_di),
    .act_func_typ (act_func_typ),
    .act_func_do  (act_func_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  function automatic int floor_div(input int n, input int d);
    int q;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  // Sigmoid approximation with arguments/results in units of 1/256
  function automatic int sig_fine(input int v);
    int a;
    int y;
    a = (v < 0) ? -v : v;
    if (a >= 5 * 256)      y = 256;
    else if (a >= 608)     y = a / 32 + 216;   // 2.375 .. 5.0: 0.03125a + 0.84375
    else if (a >= 256)     y = a / 8 + 160;    // 1.0 .. 2.375: 0.125a + 0.625
    else                   y = a / 4 + 128;    // below 1.0:    0.25a + 0.5
    return (v < 0) ? 256 - y : y;
  endfunction

  function automatic int to_out(input int y);
    int r;
    r = floor_div(y + 8, 16);
    if (r > 16)  r = 16;
    if (r < -16) r = -16;
    return r;
  endfunction

  // Reference for one sample; x is the signed input in units of 1/16
  function automatic logic [7:0] ref_act(input int typ, input logic [7:0] di);
    int x;
    int r;
    x = int'($signed(di));
    case (typ)
      0: r = (x < 0) ? 0 : x;
      1: r = (x < 0) ? 0 : ((x > 96) ? 96 : x);
      2: r = to_out(sig_fine(x * 16));
      3: r = to_out(2 * sig_fine(2 * x * 16) - 256);
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  // One clock: drive on negedge, update model at posedge, sample 1 time unit later
  task automatic step(input logic rst, input logic en, input logic [2:0] typ, input logic [7:0] di);
    @(negedge clk);
    reset = rst;
    enb = en;
    act_func_typ = typ;
    act_func_di = di;
    @(posedge clk);
    if (rst)     model_q = 8'h00;
    else if (en) model_q = ref_act(int'(typ), di);
    #1;
  endtask

  task automatic dstep(input string tag, input logic rst, input logic en, input logic [2:0] typ,
                       input logic [7:0] di, input logic [7:0] exp);
    step(rst, en, typ, di);
    check(tag, act_func_do, exp);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_q = 8'h00;
    reset = 1'b1;
    enb = 1'b1;
    act_func_typ = 3'd0;
    act_func_di = 8'h35;

    // Reset and enable
    dstep("rst0", 1'b1, 1'b1, 3'd0, 8'h35, 8'h00);
    dstep("rst1", 1'b1, 1'b1, 3'd0, 8'h35, 8'h00);
    dstep("rst_rel", 1'b0, 1'b1, 3'd0, 8'h35, 8'h35);
    dstep("enb_hold", 1'b0, 1'b0, 3'd0, 8'h10, 8'h35);
    dstep("enb_back", 1'b0, 1'b1, 3'd0, 8'h10, 8'h10);

    // RELU
    dstep("relu_24", 1'b0, 1'b1, 3'd0, 8'h24, 8'h24);
    dstep("relu_dc", 1'b0, 1'b1, 3'd0, 8'hDC, 8'h00);
    dstep("relu_80", 1'b0, 1'b1, 3'd0, 8'h80, 8'h00);
    dstep("relu_7f", 1'b0, 1'b1, 3'd0, 8'h7F, 8'h7F);

    // RELU6
    dstep("relu6_50", 1'b0, 1'b1, 3'd1, 8'h50, 8'h50);
    dstep("relu6_60", 1'b0, 1'b1, 3'd1, 8'h60, 8'h60);
    dstep("relu6_61", 1'b0, 1'b1, 3'd1, 8'h61, 8'h60);
    dstep("relu6_7f", 1'b0, 1'b1, 3'd1, 8'h7F, 8'h60);
    dstep("relu6_f1", 1'b0, 1'b1, 3'd1, 8'hF1, 8'h00);

    // SIGMOID
    dstep("sig_00", 1'b0, 1'b1, 3'd2, 8'h00, 8'h08);
    dstep("sig_10", 1'b0, 1'b1, 3'd2, 8'h10, 8'h0C);
    dstep("sig_f0", 1'b0, 1'b1, 3'd2, 8'hF0, 8'h04);
    dstep("sig_50", 1'b0, 1'b1, 3'd2, 8'h50, 8'h10);
    dstep("sig_80", 1'b0, 1'b1, 3'd2, 8'h80, 8'h00);
    dstep("sig_28", 1'b0, 1'b1, 3'd2, 8'h28, 8'h0F);

    // TANH
    dstep("tanh_00", 1'b0, 1'b1, 3'd3, 8'h00, 8'h00);
    dstep("tanh_10", 1'b0, 1'b1, 3'd3, 8'h10, 8'h0C);
    dstep("tanh_f0", 1'b0, 1'b1, 3'd3, 8'hF0, 8'hF4);
    dstep("tanh_40", 1'b0, 1'b1, 3'd3, 8'h40, 8'h10);
    dstep("tanh_80", 1'b0, 1'b1, 3'd3, 8'h80, 8'hF0);

    // Reserved select and back-to-back function changes
    dstep("rsvd_5", 1'b0, 1'b1, 3'd5, 8'h33, 8'h00);
    dstep("b2b_relu", 1'b0, 1'b1, 3'd0, 8'h70, 8'h70);
    dstep("b2b_relu6", 1'b0, 1'b1, 3'd1, 8'h70, 8'h60);
    dstep("b2b_sig", 1'b0, 1'b1, 3'd2, 8'h70, 8'h10);
    dstep("b2b_tanh", 1'b0, 1'b1, 3'd3, 8'h70, 8'h10);

    // Randomized stimulus against the reference model
    model_q = act_func_do === 8'h10 ? 8'h10 : 8'h10;
    for (int i = 0; i < 400; i++) begin
      logic r_rst;
      logic r_en;
      logic [2:0] r_typ;
      logic [7:0] r_di;
      r_rst = ($urandom_range(0, 99) < 4);
      r_en  = ($urandom_range(0, 99) < 80);
      r_typ = ($urandom_range(0, 99) < 85) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      r_di  = 8'($urandom);
      step(r_rst, r_en, r_typ, r_di);
      check("rand", act_func_do, model_q);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/al_accel_act_func_unit.md
Name: al_accel_act_func_unit

Overview:
- Single-cycle registered activation-function unit for the accelerator datapath.
- Applies ReLU, ReLU6, sigmoid or tanh to one signed fixed-point sample per enabled clock.
- Sits after the MAC/accumulator requantisation stage and feeds the output buffer.
- Sigmoid and tanh use a piecewise-linear (PLAN) approximation; no lookup RAM.

Parameters:
- DATA_W, 8: sample width, two's-complement.
- FRAC_W, 4: fractional bits (default Q3.4, so 1.0 = 16, 6.0 = 96).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-high.
- enb  input  1  enable; output register loads only when high.
- act_func_di  input  DATA_W  signed input sample.
- act_func_typ  input  3  function select: 0 RELU, 1 RELU6, 2 SIGMOID, 3 TANH, 4-7 reserved.
- act_func_do  output  DATA_W  signed result, registered.

Behaviour:
- Reset: act_func_do = 0 on the first rising clk with reset=1. Reset has priority over enb.
- Latency: result of (act_func_di, act_func_typ) sampled at edge N appears on act_func_do right after edge N, when enb=1.
- enb=0: act_func_do holds its value, and inputs are ignored.
- Function logic is combinational; only act_func_do is registered.
- RELU: x<0 -> 0; otherwise x.
- RELU6: x<0 -> 0; x>6.0 (i.e. >6<<FRAC_W) -> 6<<FRAC_W; otherwise x. If 6.0 is not representable, saturate to the max positive value.
- SIGMOID, internal arithmetic:
  - Compute on |x| extended to FRAC_W+4 fractional bits, in at least DATA_W+8 bits signed. No internal overflow is permitted.
- SIGMOID, PWL segments for a = |x|:
  - a>=5.0 -> 1.0
  - 2.375<=a<5.0 -> 0.03125a+0.84375
  - 1.0<=a<2.375 -> 0.125a+0.625
  - a<1.0 -> 0.25a+0.5
  - x<0 -> 1.0 - y(|x|)
  - Slopes are right-shifts (a>>5, a>>3, a>>2); no multipliers.
- TANH:
  - y = 2*sigmoid_pwl(2x) - 1.0.
  - 2x is formed in the widened internal width, so there is no wrap for x = most-negative input.
- Output rounding (SIGMOID and TANH):
  - Add 2^3, then arithmetic-shift right by 4, back to FRAC_W fractional bits.
  - Clamp to [-1.0, +1.0]; tanh is additionally clamped to the representable range.
- Most-negative input (e.g. 0x80):
  - RELU/RELU6 -> 0.
  - SIGMOID -> 0.
  - TANH -> -1.0 (0xF0).
- Reserved act_func_typ 4-7 -> output 0 (registered like any other result).
- act_func_typ may change every cycle; there is no internal state other than the output register.

Test Plan:
- Reset and enable:
  - reset=1 for 2 clocks with enb=1 and act_func_di=0x35 -> act_func_do=0x00.
  - Release reset -> 0x35 (RELU) one edge later.
  - Drop enb for one cycle while changing di to 0x10 -> output stays 0x35, then 0x10 after enb returns.
- RELU (typ=0):
  - di=0x24 -> 0x24; di=0xDC -> 0x00; di=0x80 -> 0x00; di=0x7F -> 0x7F.
- RELU6 (typ=1):
  - di=0x50 -> 0x50; di=0x60 -> 0x60; di=0x61 -> 0x60; di=0x7F -> 0x60; di=0xF1 -> 0x00.
- SIGMOID (typ=2):
  - di=0x00 -> 0x08; di=0x10 -> 0x0C; di=0xF0 -> 0x04.
  - di=0x50 -> 0x10; di=0x80 -> 0x00.
  - di=0x28 (2.5) -> 0.921875 -> 0x0F.
- TANH (typ=3):
  - di=0x00 -> 0x00; di=0x10 -> 0x0C; di=0xF0 -> 0xF4.
  - di=0x40 -> 0x10; di=0x80 -> 0xF0.
- Reserved select and back-to-back changes:
  - typ=5, di=0x33 -> 0x00.
  - Alternate typ 0/1/2/3 every cycle with di=0x70 -> 0x70, 0x60, 0x10, 0x10 on consecutive edges.
